li_expander: RTL and testbench

LI_EXPANDER -- requirements
Module: li_expander

---
 rtl/li_expander.sv | 76 +++++++
 tb/tb_li_expander.sv | 139 +++++++++++++
 2 files changed

// File: rtl/li_expander.sv
// li_expander: expands a load-immediate request into one or two MIPS instruction words.
// Optional two-word request counter expand_cnt when LI_EXPANDER_STATS_EN is defined.
module li_expander #(
  parameter int STATS_W = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rt,
  input  logic [31:0] in_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last
`ifdef LI_EXPANDER_STATS_EN
  ,
  output logic [STATS_W-1:0] expand_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, EMIT_ONE, EMIT_HI, EMIT_LO} state_t;
  state_t state, state_nx;
  logic [31:0] instr_nx, first_word;
  logic        last_nx, fit_s16, two_word, take, acc;
  logic [4:0]  rt_q, rt_nx;
  logic [15:0] lo_q, lo_nx;
  assign fit_s16 = &in_value[31:15] | ~|in_value[31:15];
  assign two_word = in_rt != 5'd0 && !fit_s16 && in_value[31:16] != 16'h0 && in_value[15:0] != 16'h0;
  assign first_word = in_rt == 5'd0 ? 32'h0 :
                      fit_s16 ? {6'h09, 5'd0, in_rt, in_value[15:0]} :
                      in_value[31:16] == 16'h0 ? {6'h0D, 5'd0, in_rt, in_value[15:0]} :
                      {6'h0F, 5'd0, in_rt, in_value[31:16]};
  assign out_valid = state != IDLE;
  assign take = out_valid && out_ready;
  assign in_ready = resetn && (state == IDLE || (take && out_last));
  assign acc = in_valid && in_ready;
  always_comb begin
    state_nx = state;
    instr_nx = out_instr;
    last_nx = out_last;
    rt_nx = rt_q;
    lo_nx = lo_q;
    if (acc) begin
      state_nx = two_word ? EMIT_HI : EMIT_ONE;
      instr_nx = first_word;
      last_nx = !two_word;
      rt_nx = in_rt;
      lo_nx = in_value[15:0];
    end else if (take) begin
      state_nx = state == EMIT_HI ? EMIT_LO : IDLE;
      instr_nx = state == EMIT_HI ? {6'h0D, rt_q, rt_q, lo_q} : out_instr;
      last_nx = state == EMIT_HI ? 1'b1 : out_last;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      out_instr <= 32'h0;
      out_last <= 1'b0;
      rt_q <= 5'd0;
      lo_q <= 16'h0;
    end else begin
      state <= state_nx;
      out_instr <= instr_nx;
      out_last <= last_nx;
      rt_q <= rt_nx;
      lo_q <= lo_nx;
    end
  end
`ifdef LI_EXPANDER_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetn) expand_cnt <= '0;
    else if (acc && two_word) expand_cnt <= expand_cnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_li_expander.sv
// tb_li_expander: directed and random checks of li_expander against a word-queue reference model.
module tb_li_expander;
  localparam int unsigned OP = 32'd67108864;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [4:0]  in_rt = 5'd0;
  logic [31:0] in_value = 32'h0;
  logic        in_ready, out_valid, out_last;
  logic [31:0] out_instr;
`ifdef LI_EXPANDER_STATS_EN
  logic [15:0] expand_cnt;
`endif
  logic [32:0] q[$];
  int unsigned m_cnt;
  bit          rst_seen;
  int          n_assert = 0;
  int          n_fail = 0;

  li_expander #(.STATS_W(16)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_rt(in_rt), .in_value(in_value), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_last(out_last)
`ifdef LI_EXPANDER_STATS_EN
    , .expand_cnt(expand_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic void expand(input int unsigned r, input logic [31:0] v);
    int sv;
    int unsigned hi, lo;
    sv = $signed(v);
    hi = v / 65536;
    lo = v % 65536;
    if (r == 0) q.push_back({1'b1, 32'h0});
    else if (sv >= -32768 && sv <= 32767) q.push_back({1'b1, 9 * OP + r * 65536 + lo});
    else if (hi == 0) q.push_back({1'b1, 13 * OP + r * 65536 + lo});
    else if (lo == 0) q.push_back({1'b1, 15 * OP + r * 65536 + hi});
    else begin
      q.push_back({1'b0, 15 * OP + r * 65536 + hi});
      q.push_back({1'b1, 13 * OP + r * 2097152 + r * 65536 + lo});
      m_cnt++;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input bit rn, input bit iv, input logic [4:0] r, input logic [31:0] v, input bit ordy);
    bit m_valid, m_rdy;
    resetn = rn;
    in_valid = iv;
    in_rt = r;
    in_value = v;
    out_ready = ordy;
    #1;
    m_valid = q.size() > 0;
    m_rdy = rn && (!m_valid || (ordy && q[0][32]));
    chk("in_ready", 32'(in_ready), 32'(m_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk("out_instr", out_instr, q[0][31:0]);
      chk("out_last", 32'(out_last), 32'(q[0][32]));
    end else if (rst_seen) begin
      chk("rst_instr", out_instr, 32'h0);
      chk("rst_last", 32'(out_last), 32'h0);
    end
`ifdef LI_EXPANDER_STATS_EN
    chk("expand_cnt", 32'(expand_cnt), m_cnt % 65536);
`endif
    @(posedge clk);
    if (!rn) begin
      q.delete();
      m_cnt = 0;
      rst_seen = 1'b1;
    end else begin
      if (m_valid && ordy) void'(q.pop_front());
      if (iv && m_rdy) begin
        expand(r, v);
        rst_seen = 1'b0;
      end
    end
    #1;
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 4))
      0: return 32'($signed(16'($urandom)));
      1: return {16'h0, 16'($urandom)};
      2: return {16'($urandom), 16'h0};
      3: return {16'($urandom), 15'($urandom), 1'b1};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    m_cnt = 0;
    rst_seen = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 1, 5'd8, 32'h5, 1);
    cyc(0, 0, 5'd8, 32'h5, 1);
    cyc(1, 1, 5'd8, 32'h0000_0005, 1);
    cyc(1, 0, 5'd0, 32'h0, 1);
    cyc(1, 1, 5'd8, 32'hFFFF_8000, 1);
    cyc(1, 1, 5'd8, 32'h0000_8000, 1);
    cyc(1, 1, 5'd8, 32'h1234_0000, 1);
    cyc(1, 0, 5'd0, 32'h0, 1);
    cyc(1, 1, 5'd8, 32'h1234_5678, 1);
    cyc(1, 1, 5'd9, 32'hAAAA_5555, 1);
    cyc(1, 0, 5'd0, 32'h0, 1);
    cyc(1, 0, 5'd0, 32'h0, 1);
    cyc(1, 1, 5'd8, 32'h1234_5678, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 5'd3, $urandom, 0);
    cyc(1, 0, 5'd0, 32'hFFFF_FFFF, 1);
    cyc(1, 0, 5'd0, 32'h0, 1);
    cyc(1, 0, 5'd0, 32'h0, 1);
    cyc(1, 1, 5'd8, 32'h1234_5678, 1);
    cyc(1, 0, 5'd0, 32'h0, 1);
    cyc(0, 0, 5'd0, 32'h0, 1);
    cyc(1, 0, 5'd0, 32'h0, 1);
    cyc(1, 0, 5'd0, 32'h0, 1);
    cyc(1, 1, 5'd0, 32'hDEAD_BEEF, 1);
    cyc(1, 0, 5'd0, 32'h0, 1);
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 199) != 0, 1'($urandom), $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom),
          rand_val(), $urandom_range(0, 3) != 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
